// File: rtl/genius_round_sequencer_pkg.sv
// Shared state encodings, symbol codes and the press-match helper for the Genius round sequencer.
package genius_round_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_SHOW_ON      = 3'd1,
    S_SHOW_OFF     = 3'd2,
    S_ARM          = 3'd3,
    S_WAIT_PRESS   = 3'd4,
    S_WAIT_RELEASE = 3'd5,
    S_DONE         = 3'd6
  } state_t;

  localparam logic [1:0] SYM_0    = 2'd0;
  localparam logic [1:0] SYM_1    = 2'd1;
  localparam logic [1:0] SYM_2    = 2'd2;
  localparam logic [1:0] SYM_NONE = 2'd3;

  // Exactly one button down and it is the one for the expected symbol; SYM_NONE never matches.
  function automatic logic press_ok(input logic [2:0] buttons, input logic [1:0] sym);
    return (sym != SYM_NONE) && (buttons == (3'b001 << sym));
  endfunction

endpackage

// File: rtl/genius_round_sequencer_tick_timer.sv
// Tick-enabled phase timer: counts ticks since last clear, flags the tick that completes `limit` ticks.
module genius_round_sequencer_tick_timer #(
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          tick,
  input  logic [CW-1:0] limit,
  output logic          expire
);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

  assign expire = tick && (count == limit - 1'b1);

endmodule

// File: rtl/genius_round_sequencer.sv
// One Genius round: show level+1 symbols, then check the player's presses in order.
// Optional press timeout is built only when GENIUS_TIMEOUT_EN is defined.
module genius_round_sequencer
  import genius_round_sequencer_pkg::*;
#(
  parameter int ON_TICKS      = 4,
  parameter int OFF_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 20,
  parameter int CW            = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       round_start,
  input  logic [3:0] level,
  input  logic [1:0] seq_symbol,
  input  logic [2:0] btn,
  output logic [3:0] seq_index,
  output logic       show_valid,
  output logic [1:0] show_symbol,
  output logic       busy,
  output logic       round_done,
  output logic       round_pass,
  output logic [3:0] progress
);

  state_t        state;
  logic [3:0]    level_q;
  logic [CW-1:0] limit;
  logic          timed;
  logic          expire;

  always_comb begin
    limit = CW'(ON_TICKS);
    case (state)
      S_SHOW_OFF:   limit = CW'(OFF_TICKS);
      S_WAIT_PRESS: limit = CW'(TIMEOUT_TICKS);
      default:      limit = CW'(ON_TICKS);
    endcase
  end

  // Timer is held clear outside timed states, so every entry into one starts from zero.
`ifdef GENIUS_TIMEOUT_EN
  assign timed = (state == S_SHOW_ON) || (state == S_SHOW_OFF) || (state == S_WAIT_PRESS);
`else
  assign timed = (state == S_SHOW_ON) || (state == S_SHOW_OFF);
`endif

  genius_round_sequencer_tick_timer #(.CW(CW)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!timed || expire),
    .tick   (tick),
    .limit  (limit),
    .expire (expire)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      level_q    <= '0;
      seq_index  <= '0;
      progress   <= '0;
      round_pass <= 1'b0;
      round_done <= 1'b0;
    end else begin
      round_done <= 1'b0;
      case (state)
        S_IDLE: if (round_start) begin
          state      <= S_SHOW_ON;
          level_q    <= level;
          seq_index  <= '0;
          progress   <= '0;
          round_pass <= 1'b0;
        end
        S_SHOW_ON: if (expire) state <= S_SHOW_OFF;
        S_SHOW_OFF: if (expire) begin
          if (seq_index == level_q) begin
            state     <= S_ARM;
            seq_index <= '0;
          end else begin
            state     <= S_SHOW_ON;
            seq_index <= seq_index + 1'b1;
          end
        end
        S_ARM: if (btn == 3'b000) state <= S_WAIT_PRESS;
        S_WAIT_PRESS: begin
          // A press on the expiring tick still counts as a press.
          if (btn != 3'b000) begin
            if (press_ok(btn, seq_symbol)) begin
              progress <= progress + 1'b1;
              state    <= S_WAIT_RELEASE;
            end else begin
              state      <= S_DONE;
              round_done <= 1'b1;
              round_pass <= 1'b0;
            end
          end
`ifdef GENIUS_TIMEOUT_EN
          else if (expire) begin
            state      <= S_DONE;
            round_done <= 1'b1;
            round_pass <= 1'b0;
          end
`endif
        end
        S_WAIT_RELEASE: if (btn == 3'b000) begin
          if (seq_index == level_q) begin
            state      <= S_DONE;
            round_done <= 1'b1;
            round_pass <= 1'b1;
          end else begin
            state     <= S_WAIT_PRESS;
            seq_index <= seq_index + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign show_valid  = (state == S_SHOW_ON);
  assign show_symbol = show_valid ? seq_symbol : SYM_0;
  assign busy        = (state != S_IDLE);

endmodule
